// File: rtl/traffic_phase_ctrl.sv
// Multi-phase traffic signal controller: GREEN -> YELLOW -> ALLRED rotation driven by per-phase demand.
// Define TRAFFIC_PED_EN to add pedestrian walk requests (ped_req) and walk lamps (walk).
module traffic_phase_ctrl #(
  parameter int NUM_PHASES   = 2,
  parameter int GREEN_TICKS  = 30,
  parameter int YELLOW_TICKS = 5,
  parameter int ALLRED_TICKS = 2,
  parameter int CNT_W        = 8
`ifdef TRAFFIC_PED_EN
  ,parameter int WALK_TICKS  = 8
`endif
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          tick,
  input  logic [NUM_PHASES-1:0]         req,
`ifdef TRAFFIC_PED_EN
  input  logic [NUM_PHASES-1:0]         ped_req,
  output logic [NUM_PHASES-1:0]         walk,
`endif
  output logic [NUM_PHASES-1:0]         red,
  output logic [NUM_PHASES-1:0]         yellow,
  output logic [NUM_PHASES-1:0]         green,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase
);

  localparam int     AW      = $clog2(NUM_PHASES);
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  if (NUM_PHASES < 2 || NUM_PHASES > 8) begin : g_bad_phases
    $error("traffic_phase_ctrl: NUM_PHASES must be in 2..8");
  end
  if (GREEN_TICKS < 1 || GREEN_TICKS > CNT_MAX) begin : g_bad_green
    $error("traffic_phase_ctrl: GREEN_TICKS must be >= 1 and fit in CNT_W bits");
  end
  if (YELLOW_TICKS < 1 || YELLOW_TICKS > CNT_MAX) begin : g_bad_yellow
    $error("traffic_phase_ctrl: YELLOW_TICKS must be >= 1 and fit in CNT_W bits");
  end
  if (ALLRED_TICKS < 1 || ALLRED_TICKS > CNT_MAX) begin : g_bad_allred
    $error("traffic_phase_ctrl: ALLRED_TICKS must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);

  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_count;
  logic [AW-1:0]         r_active_phase;
  logic [NUM_PHASES-1:0] r_pending;

  logic [NUM_PHASES-1:0] w_active_mask;
  logic [NUM_PHASES-1:0] w_next_mask;
  logic [NUM_PHASES-1:0] w_req_masked;
  logic [AW-1:0]         w_next_phase;
  logic                  w_found;
  logic                  w_other_demand;
  logic                  w_enter_green;

  assign w_active_mask  = NUM_PHASES'(1) << r_active_phase;
  assign w_next_mask    = NUM_PHASES'(1) << w_next_phase;
  assign w_other_demand = |(r_pending & ~w_active_mask);
  assign w_enter_green  = tick && (r_count == '0) && (r_state == S_ALLRED);
  assign w_req_masked   = req & ~((r_state == S_GREEN) ? w_active_mask : '0);
  assign active_phase   = r_active_phase;

  // Round-robin search for the next phase, starting just after the current owner.
  always_comb begin
    logic [AW-1:0] idx;
    idx          = '0;
    w_found      = 1'b0;
    w_next_phase = r_active_phase;
    for (int off = 1; off <= NUM_PHASES; off++) begin
      idx = AW'((int'(r_active_phase) + off) % NUM_PHASES);
      if (!w_found && r_pending[idx]) begin
        w_found      = 1'b1;
        w_next_phase = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_GREEN;
      r_count        <= GREEN_LOAD;
      r_active_phase <= '0;
    end else if (tick) begin
      if (r_count != '0) begin
        r_count <= r_count - 1'b1;
      end else begin
        case (r_state)
          S_GREEN: begin
            if (w_other_demand) begin
              r_state <= S_YELLOW;
              r_count <= YELLOW_LOAD;
            end
          end
          S_YELLOW: begin
            r_state <= S_ALLRED;
            r_count <= ALLRED_LOAD;
          end
          S_ALLRED: begin
            r_state        <= S_GREEN;
            r_count        <= GREEN_LOAD;
            r_active_phase <= w_next_phase;
          end
          default: begin
            r_state <= S_GREEN;
            r_count <= GREEN_LOAD;
          end
        endcase
      end
    end
  end

  // A phase entering GREEN drops any request arriving on that same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending | w_req_masked
`ifdef TRAFFIC_PED_EN
                    | (ped_req & ~((r_state == S_GREEN) ? w_active_mask : '0))
`endif
                   ) & ~(w_enter_green ? w_next_mask : '0);
    end
  end

  always_comb begin
    red    = '1;
    yellow = '0;
    green  = '0;
    case (r_state)
      S_GREEN: begin
        green = w_active_mask;
        red   = ~w_active_mask;
      end
      S_YELLOW: begin
        yellow = w_active_mask;
        red    = ~w_active_mask;
      end
      default: ;
    endcase
  end

`ifdef TRAFFIC_PED_EN
  if (WALK_TICKS < 1 || WALK_TICKS > GREEN_TICKS) begin : g_bad_walk
    $error("traffic_phase_ctrl: WALK_TICKS must be in 1..GREEN_TICKS");
  end

  localparam logic [CNT_W-1:0] WALK_LOAD = CNT_W'(WALK_TICKS - 1);

  logic [NUM_PHASES-1:0] r_ped_pending;
  logic                  r_walk;
  logic [CNT_W-1:0]      r_walk_count;

  // Walk runs for the first WALK_TICKS ticks of a GREEN that was entered with a pedestrian waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ped_pending <= '0;
      r_walk        <= 1'b0;
      r_walk_count  <= '0;
    end else begin
      r_ped_pending <= (r_ped_pending | (ped_req & ~((r_state == S_GREEN) ? w_active_mask : '0)))
                       & ~(w_enter_green ? w_next_mask : '0);
      if (w_enter_green) begin
        r_walk       <= r_ped_pending[w_next_phase];
        r_walk_count <= WALK_LOAD;
      end else if (r_state != S_GREEN) begin
        r_walk <= 1'b0;
      end else if (tick && r_walk) begin
        if (r_walk_count == '0) begin
          r_walk <= 1'b0;
        end else begin
          r_walk_count <= r_walk_count - 1'b1;
        end
      end
    end
  end

  assign walk = (r_walk && r_state == S_GREEN) ? w_active_mask : '0;
`endif

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 Parameter NUM_PHASES, default 2; number of conflicting signal phases, legal range 2..8.
REQ-002 Parameter GREEN_TICKS, default 30; minimum green duration in ticks, at least 1.
REQ-003 Parameter YELLOW_TICKS, default 5; yellow duration in ticks, at least 1.
REQ-004 Parameter ALLRED_TICKS, default 2; all-red clearance duration in ticks, at least 1.
REQ-005 Parameter CNT_W, default 8; down-counter width; every *_TICKS value SHALL fit in CNT_W bits, otherwise elaboration SHALL fail.
REQ-006 clk  input  1  single clock for all state.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 tick  input  1  one-clk timebase enable pulse; timing advances only on clk edges where tick=1.
REQ-009 req  input  NUM_PHASES  per-phase vehicle demand, level or pulse, sampled every clk.
REQ-010 red  output  NUM_PHASES  per-phase red lamp.
REQ-011 yellow  output  NUM_PHASES  per-phase yellow lamp.
REQ-012 green  output  NUM_PHASES  per-phase green lamp.
REQ-013 active_phase  output  clog2(NUM_PHASES)  index of the phase owning right-of-way.

Function
REQ-014 The FSM SHALL have states GREEN, YELLOW and ALLRED, plus a registered active_phase and a CNT_W-bit down-counter.
REQ-015 On a tick with count>0, count SHALL decrement and the state SHALL hold; edges with tick=0 SHALL change neither count nor state.
REQ-016 On a tick with count==0 in GREEN, a transition SHALL occur only if any pending bit of another phase is set.
- If one is set: next state YELLOW, count loaded with YELLOW_TICKS-1.
- Otherwise: GREEN holds with count at 0, and the condition is re-evaluated on every tick.
REQ-017 On a tick with count==0 in YELLOW: next state ALLRED, count loaded with ALLRED_TICKS-1.
REQ-018 On a tick with count==0 in ALLRED: next state GREEN, count loaded with GREEN_TICKS-1, and active_phase set to the first phase with a pending bit, searching upward from active_phase+1 with wrap-around.
REQ-019 Each state SHALL therefore last exactly its *_TICKS ticks; GREEN lasts longer only while no other phase has demand.
REQ-020 A pending register, NUM_PHASES bits wide, SHALL OR in req each clk, except for the bit of active_phase while in GREEN, which SHALL NOT be set.
REQ-021 The pending bit of a phase SHALL clear on the edge that phase enters GREEN; a simultaneous req for that phase SHALL be dropped (clear wins).
REQ-022 Lamp decode SHALL be combinational from the registered state and SHALL take effect in the same cycle as the state change.
REQ-023 In GREEN, the active phase SHALL show green only; in YELLOW, it SHALL show yellow only; all other phases, and all phases in ALLRED, SHALL show red only.
REQ-024 Exactly one of red/yellow/green SHALL be high per phase at all times, and at most one phase SHALL be non-red.

Reset
REQ-025 While reset_n=0, the block SHALL hold state=GREEN, active_phase=0, count=GREEN_TICKS-1 and pending=0.
- Lamps: green[0]=1; red=1 for all other phases.
REQ-026 Reset assertion mid-cycle, in any state, SHALL immediately force the REQ-025 values without waiting for clk.
REQ-027 The first tick after release SHALL count normally.

Configuration
REQ-028 Macro TRAFFIC_PED_EN SHALL compile in pedestrian support. With it defined:
- Parameter WALK_TICKS, default 8, legal range 1..GREEN_TICKS.
- Input ped_req [NUM_PHASES].
- Output walk [NUM_PHASES].
- ped_req SHALL set both the demand pending bit and a ped_pending bit of its phase.
- On GREEN entry with ped_pending set, walk of that phase SHALL be high for the first WALK_TICKS ticks of GREEN, and ped_pending SHALL clear.
- walk SHALL be low in all other states and after reset.
Without the macro, ped_req, walk and all pedestrian logic SHALL be absent, and behaviour SHALL equal REQ-014..REQ-027.

Verification
REQ-029 Defaults, tick=1 every clk, no req after reset -> green[0] held for at least 100 cycles; red[1]=1 throughout.
REQ-030 Defaults, tick=1, req[1] pulsed at cycle 5 -> timeline, counted in cycles after reset release:
- cycles 0-29: green[0].
- cycles 30-34: yellow[0].
- cycles 35-36: all red.
- cycle 37: green[1], active_phase=1.
REQ-031 NUM_PHASES=4, req[0] and req[2] pulsed while phase 1 is green -> next GREEN is phase 2, then phase 0 (wrap order).
REQ-032 tick asserted once every 3 clks -> all state durations scale by 3; a req pulse landing on the same edge as that phase's GREEN entry is not latched.
REQ-033 reset_n asserted during YELLOW of phase 1 -> immediately green[0]=1, pending=0; with TRAFFIC_PED_EN defined, ped_req[1] yields walk[1]=1 for the first 8 ticks of phase 1 GREEN.
